// File: rtl/gain_div.sv
`default_nettype none
// ============================================================================
//  Module      : gain_div
//  Description : Sequential fixed-point divider, q = (num * 2^FRAC) / den.
//                Inverse of the gain multiplier: normalises a signed level by
//                an unsigned Q.FRAC gain word. Restoring division, one
//                quotient bit per clock, rounding toward zero.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                in_valid/in_ready - operand handshake
//                in_num            - signed dividend (DW)
//                in_den            - unsigned divisor, Q.FRAC (DW)
//                out_valid/ready   - result handshake
//                out_q             - signed quotient (DW)
//                out_sat           - quotient clipped to DW-bit signed range
//                out_div0          - divisor was zero
//  Revision    : 1.0  initial release
// ============================================================================
module gain_div #(
    parameter int DW   = 32,
    parameter int FRAC = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_num,
    input  logic        [DW-1:0] in_den,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_q,
    output logic                 out_sat,
    output logic                 out_div0
);

    localparam int ITER = DW + FRAC;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [CW-1:0] c_last = CW'(ITER - 1);

    // Magnitude limits of the DW-bit signed range, widened to quotient width.
    localparam logic [ITER-1:0] c_pos_lim = {{(FRAC + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic [ITER-1:0] c_neg_lim = {{FRAC{1'b0}}, 1'b1, {(DW - 1){1'b0}}};
    localparam logic [DW-1:0]   c_max     = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0]   c_min     = {1'b1, {(DW - 1){1'b0}}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]      r_state_q, w_state_d;
    logic [CW-1:0]   r_cnt_q,   w_cnt_d;
    logic            r_neg_q,   w_neg_d;
    logic [DW-1:0]   r_den_q,   w_den_d;
    logic [DW-1:0]   r_rem_q,   w_rem_d;
    logic [ITER-1:0] r_quo_q,   w_quo_d;    // dividend bits out, quotient bits in
    logic [DW-1:0]   r_res_q,   w_res_d;
    logic            r_sat_q,   w_sat_d;
    logic            r_div0_q,  w_div0_d;
    logic            r_valid_q, w_valid_d;
    logic            r_ready_q, w_ready_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    // A DW-bit unsigned negate is enough: -2^(DW-1) maps to 2^(DW-1), which
    // still fits as an unsigned value.
    logic [DW-1:0]   w_num_mag;
    logic [DW:0]     w_rem_sh;
    logic            w_ge;
    logic [DW-1:0]   w_rem_sub;
    logic [DW-1:0]   w_rem_nx;
    logic [ITER-1:0] w_quo_nx;
    logic [DW-1:0]   w_fin_res;
    logic            w_fin_sat;

    always_comb begin
        w_num_mag = in_num[DW-1] ? (~in_num + 1'b1) : in_num;

        // One restoring step: bring in the next dividend bit, try to subtract.
        w_rem_sh  = {r_rem_q, r_quo_q[ITER-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_den_q});
        // The remainder stays below den, so the difference fits DW bits.
        w_rem_sub = w_rem_sh[DW-1:0] - r_den_q;
        w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[DW-1:0];
        w_quo_nx  = {r_quo_q[ITER-2:0], w_ge};

        // Final sign/saturation, evaluated on the quotient of the last step.
        w_fin_res = '0;
        w_fin_sat = 1'b0;
        if (r_neg_q) begin
            if (w_quo_nx > c_neg_lim) begin
                w_fin_res = c_min;
                w_fin_sat = 1'b1;
            end else begin
                w_fin_res = ~w_quo_nx[DW-1:0] + 1'b1;
            end
        end else begin
            if (w_quo_nx > c_pos_lim) begin
                w_fin_res = c_max;
                w_fin_sat = 1'b1;
            end else begin
                w_fin_res = w_quo_nx[DW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_neg_d   = r_neg_q;
        w_den_d   = r_den_q;
        w_rem_d   = r_rem_q;
        w_quo_d   = r_quo_q;
        w_res_d   = r_res_q;
        w_sat_d   = r_sat_q;
        w_div0_d  = r_div0_q;
        w_valid_d = r_valid_q;
        w_ready_d = r_ready_q;

        case (r_state_q)
            c_idle: begin
                if (in_valid && r_ready_q) begin
                    w_neg_d   = in_num[DW-1];
                    w_den_d   = in_den;
                    w_rem_d   = '0;
                    w_quo_d   = {w_num_mag, {FRAC{1'b0}}};
                    w_cnt_d   = '0;
                    w_ready_d = 1'b0;
                    if (in_den == '0) begin
                        // Divide by zero resolves immediately to a clipped result.
                        w_state_d = c_done;
                        w_res_d   = in_num[DW-1] ? c_min : c_max;
                        w_sat_d   = 1'b1;
                        w_div0_d  = 1'b1;
                        w_valid_d = 1'b1;
                    end else begin
                        w_state_d = c_calc;
                        w_res_d   = '0;
                        w_sat_d   = 1'b0;
                        w_div0_d  = 1'b0;
                    end
                end
            end

            c_calc: begin
                w_rem_d = w_rem_nx;
                w_quo_d = w_quo_nx;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_last) begin
                    w_state_d = c_done;
                    w_res_d   = w_fin_res;
                    w_sat_d   = w_fin_sat;
                    w_valid_d = 1'b1;
                end
            end

            c_done: begin
                if (out_ready) begin
                    w_state_d = c_idle;
                    w_valid_d = 1'b0;
                    w_ready_d = 1'b1;
                end
            end

            default: begin
                w_state_d = c_idle;
                w_valid_d = 1'b0;
                w_ready_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_idle;
            r_cnt_q   <= '0;
            r_neg_q   <= 1'b0;
            r_den_q   <= '0;
            r_rem_q   <= '0;
            r_quo_q   <= '0;
            r_res_q   <= '0;
            r_sat_q   <= 1'b0;
            r_div0_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_ready_q <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_neg_q   <= w_neg_d;
            r_den_q   <= w_den_d;
            r_rem_q   <= w_rem_d;
            r_quo_q   <= w_quo_d;
            r_res_q   <= w_res_d;
            r_sat_q   <= w_sat_d;
            r_div0_q  <= w_div0_d;
            r_valid_q <= w_valid_d;
            r_ready_q <= w_ready_d;
        end
    end

    assign in_ready  = r_ready_q;
    assign out_valid = r_valid_q;
    assign out_q     = r_res_q;
    assign out_sat   = r_sat_q;
    assign out_div0  = r_div0_q;

endmodule
`default_nettype wire

// File: tb/tb_gain_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gain_div
//  Description : Self-checking bench for gain_div (DW=32, FRAC=12). Directed
//                vector table plus handshake-stall, reset-abort and sweep
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gain_div;

    localparam int DW   = 32;
    localparam int FRAC = 12;
    localparam int ITER = DW + FRAC;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_num;
    logic        [31:0] in_den;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_q;
    logic               out_sat;
    logic               out_div0;

    gain_div #(.DW(DW), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_sat   (out_sat),
        .out_div0  (out_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [31:0] num;
        logic        [31:0] den;
        logic signed [31:0] q;
        logic               sat;
        logic               div0;
    } vec_t;

    localparam logic signed [31:0] c_max = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] c_min = 32'sh8000_0000;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge), wait for the result,
    // capture it, then complete the output handshake. lat counts rising edges
    // after the accept edge until out_valid is seen.
    task automatic do_op(input logic signed [31:0] n, input logic [31:0] d,
                         output logic signed [31:0] q, output logic sat,
                         output logic div0, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); @(negedge clk); w++;
        end
        in_num   = n;
        in_den   = d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_num   = ~n;          // later input changes must not matter
        in_den   = d + 32'd77;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        q    = out_q;
        sat  = out_sat;
        div0 = out_div0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        logic signed [31:0] q;
        logic               sat;
        logic               div0;
        int                 lat;
        longint             expq;

        tbl[0]  = '{32'sd1000,        32'd4096,        32'sd1000,      1'b0, 1'b0};
        tbl[1]  = '{-32'sd1001,       32'd8192,        -32'sd500,      1'b0, 1'b0};
        tbl[2]  = '{32'sd1001,        32'd8192,        32'sd500,       1'b0, 1'b0};
        tbl[3]  = '{32'sd5,           32'd0,           c_max,          1'b1, 1'b1};
        tbl[4]  = '{-32'sd5,          32'd0,           c_min,          1'b1, 1'b1};
        tbl[5]  = '{32'sd1073741824,  32'd1,           c_max,          1'b1, 1'b0};
        tbl[6]  = '{c_min,            32'd4096,        c_min,          1'b0, 1'b0};
        tbl[7]  = '{32'sd0,           32'd4096,        32'sd0,         1'b0, 1'b0};
        tbl[8]  = '{32'sd0,           32'd0,           c_max,          1'b1, 1'b1};
        tbl[9]  = '{c_min,            32'd1,           c_min,          1'b1, 1'b0};
        tbl[10] = '{32'sd7,           32'd3,           32'sd9557,      1'b0, 1'b0};
        tbl[11] = '{-32'sd7,          32'd3,           -32'sd9557,     1'b0, 1'b0};
        tbl[12] = '{32'sd524287,      32'd1,           32'sd2147479552,1'b0, 1'b0};
        tbl[13] = '{32'sd524288,      32'd1,           c_max,          1'b1, 1'b0};
        tbl[14] = '{-32'sd524288,     32'd1,           c_min,          1'b0, 1'b0};
        tbl[15] = '{c_min,            32'hFFFF_FFFF,   -32'sd2048,     1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_num = '0; in_den = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset in_ready",  in_ready,  1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_q",     out_q,     0);
        chk("reset out_sat",   out_sat,   0);
        chk("reset out_div0",  out_div0,  0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].num, tbl[i].den, q, sat, div0, lat);
            chk($sformatf("vec%0d q", i),    q,    tbl[i].q);
            chk($sformatf("vec%0d sat", i),  sat,  tbl[i].sat);
            chk($sformatf("vec%0d div0", i), div0, tbl[i].div0);
            // Divide-by-zero result is valid right after the accept edge.
            chk($sformatf("vec%0d latency", i), lat, (tbl[i].den == 0) ? 0 : ITER);
        end

        // ---------------- stall in DONE ----------------
        in_num = 32'sd7; in_den = 32'd3; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_num = 32'sd123; in_den = 32'd1;   // still asserted, must be ignored
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        chk("stall latency", lat, ITER);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            chk("stall q",        out_q,     9557);
            chk("stall flags",    {out_sat, out_div0}, 0);
            chk("stall valid",    out_valid, 1);
            chk("stall in_ready", in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("release out_valid", out_valid, 0);
        chk("release in_ready",  in_ready,  1);

        // ---------------- reset mid-calculation ----------------
        in_num = 32'sd1000; in_den = 32'd4096; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready",  in_ready,  1);
        chk("abort out_valid", out_valid, 0);
        chk("abort out_q",     out_q,     0);
        chk("abort flags",     {out_sat, out_div0}, 0);
        repeat (ITER) @(posedge clk);
        @(negedge clk);
        chk("abort no late result", out_valid, 0);
        do_op(-32'sd1001, 32'd8192, q, sat, div0, lat);
        chk("after abort q",   q,   -500);
        chk("after abort lat", lat, ITER);

        // ---------------- sweep ----------------
        // num over [-2^14, 2^14) step 2^7, den walked across [1, 2^14) step 2^7.
        for (int i = 0; i < 256; i++) begin
            logic signed [31:0] n;
            logic        [31:0] d;
            n = -32'sd16384 + 32'(i * 128);
            d = 32'd1 + 32'(((i * 37) % 128) * 128);
            do_op(n, d, q, sat, div0, lat);
            expq = (longint'(n) * 4096) / longint'(d);
            chk($sformatf("sweep n=%0d d=%0d", n, d), q, expq);
        end
        for (int j = 0; j < 128; j++) begin
            logic signed [31:0] n;
            logic        [31:0] d;
            n = (j % 2 == 0) ? -32'sd16384 : 32'sd16256;
            d = 32'd1 + 32'(j * 128);
            do_op(n, d, q, sat, div0, lat);
            expq = (longint'(n) * 4096) / longint'(d);
            chk($sformatf("sweep n=%0d d=%0d", n, d), q, expq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
